// File: rtl/morse_pkg.sv
// morse_pkg: definitions shared by morse_keyer, morse_tx and morse_rx.
//   - 2-bit symbol encodings on the ditDah link (dit, dah, etc/separator)
//   - letter code width and the code points for SPACE / highest valid code
//   - keyer FSM state enum
//   - morse_lookup(): letter code -> {valid, len, pat}, where pat[3] is the
//     first symbol sent (1 = dah, 0 = dit) and only the top len bits matter.
package morse_pkg;

  localparam logic [1:0] SYM_DIT = 2'b00;
  localparam logic [1:0] SYM_DAH = 2'b11;
  localparam logic [1:0] SYM_ETC = 2'b01;

  localparam int LETTER_W = 6;
  localparam logic [LETTER_W-1:0] CODE_SPACE     = 6'd26;
  localparam logic [LETTER_W-1:0] CODE_MAX_VALID = 6'd26;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_SEP  = 2'd2
  } keyer_state_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] len;
    logic [3:0] pat;
  } morse_code_t;

  // Symbol for one pattern bit.
  function automatic logic [1:0] sym_of(input logic dah);
    return dah ? SYM_DAH : SYM_DIT;
  endfunction

  function automatic morse_code_t morse_lookup(input logic [LETTER_W-1:0] code);
    morse_code_t r;
    r = '0;
    case (code)
      6'd0:  r = {1'b1, 3'd2, 4'b0100};  // A .-
      6'd1:  r = {1'b1, 3'd4, 4'b1000};  // B -...
      6'd2:  r = {1'b1, 3'd4, 4'b1010};  // C -.-.
      6'd3:  r = {1'b1, 3'd3, 4'b1000};  // D -..
      6'd4:  r = {1'b1, 3'd1, 4'b0000};  // E .
      6'd5:  r = {1'b1, 3'd4, 4'b0010};  // F ..-.
      6'd6:  r = {1'b1, 3'd3, 4'b1100};  // G --.
      6'd7:  r = {1'b1, 3'd4, 4'b0000};  // H ....
      6'd8:  r = {1'b1, 3'd2, 4'b0000};  // I ..
      6'd9:  r = {1'b1, 3'd4, 4'b0111};  // J .---
      6'd10: r = {1'b1, 3'd3, 4'b1010};  // K -.-
      6'd11: r = {1'b1, 3'd4, 4'b0100};  // L .-..
      6'd12: r = {1'b1, 3'd2, 4'b1100};  // M --
      6'd13: r = {1'b1, 3'd2, 4'b1000};  // N -.
      6'd14: r = {1'b1, 3'd3, 4'b1110};  // O ---
      6'd15: r = {1'b1, 3'd4, 4'b0110};  // P .--.
      6'd16: r = {1'b1, 3'd4, 4'b1101};  // Q --.-
      6'd17: r = {1'b1, 3'd3, 4'b0100};  // R .-.
      6'd18: r = {1'b1, 3'd3, 4'b0000};  // S ...
      6'd19: r = {1'b1, 3'd1, 4'b1000};  // T -
      6'd20: r = {1'b1, 3'd3, 4'b0010};  // U ..-
      6'd21: r = {1'b1, 3'd4, 4'b0001};  // V ...-
      6'd22: r = {1'b1, 3'd3, 4'b0110};  // W .--
      6'd23: r = {1'b1, 3'd4, 4'b1001};  // X -..-
      6'd24: r = {1'b1, 3'd4, 4'b1011};  // Y -.--
      6'd25: r = {1'b1, 3'd4, 4'b1100};  // Z --..
      6'd26: r = {1'b1, 3'd4, 4'b0011};  // SPACE ..--
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_letter_fifo.sv
// morse_letter_fifo: synchronous letter FIFO with a registered head stage.
//   Storage is an array with registered read into a head register, so the
//   consumer sees the oldest entry one cycle after it is written and can pop
//   it with no extra delay; popping refills the head on the same edge.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   push, push_data write request (ignored while full) and data
//   pop             remove the head entry (ignored while empty)
//   full            registered: DEPTH entries held (head included)
//   empty           no entry available at the head
//   head_data       oldest entry, valid while !empty
//   count_next      occupancy after the coming edge
module morse_letter_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH):0]     count_next
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic [CW-1:0]    mem_count;
  logic             head_valid_reg;
  logic [WIDTH-1:0] head_reg;
  logic             full_reg;
  logic             push_ok;
  logic             do_pop;
  logic             head_load;

  assign push_ok   = push && !full_reg;
  assign do_pop    = pop && head_valid_reg;
  // Entries still in the array (the head register holds one when valid).
  assign mem_count = count_reg - CW'(head_valid_reg);
  // Refill the head whenever it is empty or being consumed this edge.
  assign head_load = (mem_count != '0) && (!head_valid_reg || do_pop);
  assign count_next = count_reg + CW'(push_ok) - CW'(do_pop);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (head_load) begin
      head_reg <= mem[rd_ptr_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      head_valid_reg <= 1'b0;
      full_reg       <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (head_load) begin
        rd_ptr_reg     <= rd_ptr_reg + AW'(1);
        head_valid_reg <= 1'b1;
      end else if (do_pop) begin
        head_valid_reg <= 1'b0;
      end
      count_reg <= count_next;
      full_reg  <= (count_next == CW'(DEPTH));
    end
  end

  assign full      = full_reg;
  assign empty     = !head_valid_reg;
  assign head_data = head_reg;

endmodule

// File: rtl/morse_keyer.sv
// morse_keyer: buffers 6-bit letter codes and expands each into the per-clock
// ditDah symbol stream consumed by morse_tx.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   letter_in      letter code (0..25 A..Z, 26 SPACE, others invalid)
//   letter_valid   letter_in valid; transfer when valid && ready at posedge
//   letter_ready   FIFO can accept (registered, = !full)
//   ditDah         symbol: 00 dit, 11 dah, 01 separator/idle (registered)
//   busy           letter or separator in progress, or FIFO non-empty
//   bad_letter     one-cycle pulse after an invalid code was accepted
module morse_keyer import morse_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int SEP_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [LETTER_W-1:0] letter_in,
  input  logic                letter_valid,
  output logic                letter_ready,
  output logic [0:1]          ditDah,
  output logic                busy,
  output logic                bad_letter
);

  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int SEP_W = (SEP_CYCLES > 1) ? $clog2(SEP_CYCLES) : 1;

  logic                fifo_full;
  logic                fifo_empty;
  logic [LETTER_W-1:0] head_code;
  logic [CW-1:0]       fifo_count_next;
  logic                accept;
  logic                in_valid;
  logic                push;
  logic                pop;
  morse_code_t         head_info;

  keyer_state_t        state_reg, state_next;
  logic [3:0]          pat_reg, pat_next;
  logic [2:0]          cnt_reg, cnt_next;
  logic [SEP_W-1:0]    sep_reg, sep_next;
  logic [1:0]          sym_reg, sym_next;
  logic                busy_reg;
  logic                bad_reg;

  // Invalid codes still complete the handshake but never enter the FIFO.
  assign accept   = letter_valid && !fifo_full;
  assign in_valid = (letter_in <= CODE_MAX_VALID);
  assign push     = accept && in_valid;

  morse_letter_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (LETTER_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_data  (letter_in),
    .pop        (pop),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .head_data  (head_code),
    .count_next (fifo_count_next)
  );

  assign head_info = morse_lookup(head_code);

  always_comb begin
    state_next = state_reg;
    pat_next   = pat_reg;
    cnt_next   = cnt_reg;
    sep_next   = sep_reg;
    sym_next   = SYM_ETC;
    pop        = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (head_info.valid) begin
            sym_next   = sym_of(head_info.pat[3]);
            pat_next   = {head_info.pat[2:0], 1'b0};
            cnt_next   = head_info.len - 3'd1;
            state_next = ST_SEND;
          end
        end
      end
      ST_SEND: begin
        // cnt_reg counts symbols still to send after the one on the line.
        if (cnt_reg == 3'd0) begin
          sep_next   = SEP_W'(SEP_CYCLES - 1);
          state_next = ST_SEP;
        end else begin
          sym_next = sym_of(pat_reg[3]);
          pat_next = {pat_reg[2:0], 1'b0};
          cnt_next = cnt_reg - 3'd1;
        end
      end
      ST_SEP: begin
        if (sep_reg == '0) begin
          // Chain straight into the next letter so there is no idle gap.
          if (!fifo_empty) begin
            pop = 1'b1;
            if (head_info.valid) begin
              sym_next   = sym_of(head_info.pat[3]);
              pat_next   = {head_info.pat[2:0], 1'b0};
              cnt_next   = head_info.len - 3'd1;
              state_next = ST_SEND;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            state_next = ST_IDLE;
          end
        end else begin
          sep_next = sep_reg - SEP_W'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      pat_reg   <= '0;
      cnt_reg   <= '0;
      sep_reg   <= '0;
      sym_reg   <= SYM_ETC;
      busy_reg  <= 1'b0;
      bad_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pat_reg   <= pat_next;
      cnt_reg   <= cnt_next;
      sep_reg   <= sep_next;
      sym_reg   <= sym_next;
      busy_reg  <= (state_next != ST_IDLE) || (fifo_count_next != '0);
      bad_reg   <= accept && !in_valid;
    end
  end

  assign letter_ready = !fifo_full;
  assign ditDah       = sym_reg;
  assign busy         = busy_reg;
  assign bad_letter   = bad_reg;

endmodule
